bz_serializer: RTL and testbench
================================

// Module: bz_serializer
// PURPOSE
// - PC->BrainDrop direction of the router. Accepts one 32-bit word {code, payload} from the PC-side
//   Channel and splits it into DataWidth-bit flits. Each flit gets a tail bit, and the flits are
//   written into the BrainDrop-side input FIFO.
// - Packet = one head flit carrying the code, then NCHUNK payload flits. Only the last flit has tail=1.
//   The wormhole receiver reassembles the packet using the tail bit.
// PARAMETERS
// - NPCcode    8   width of code field, d[NPCcode+NPCdata-1 -: NPCcode]; must be <= DataWidth
// - NPCdata    24  width of payload field, d[NPCdata-1:0]
// - DataWidth  10  flit data width; FIFO word = DataWidth+1
// - derived: NCHUNK = ceil(NPCdata/DataWidth) (=3 default); counter width = $clog2(NCHUNK)
// PORTS
// - clk               input   1   single clock, posedge
// - reset             input   1   asynchronous, active-high
// - PC_in_channel.d   input   NPCcode+NPCdata   word from PC side (Channel.in)
// - PC_in_channel.v   input   1   word valid
// - PC_in_channel.a   output  1   ack, registered, one-cycle pulse per word consumed
// - isfull            input   1   BrainDrop-side FIFO full
// - data_out          output  DataWidth+1  flit {tail, data[DataWidth-1:0]}
// - wrreq             output  1   FIFO write strobe; flit is written on clk edge when wrreq=1
// BEHAVIOUR
// - Reset (async, any time, including mid-packet):
//   - state=IDLE, a=0, chunk counter=0, holding register=0
//   - wrreq=0 and data_out=0 while reset is high; the partial packet is dropped
// - States:
//   - IDLE: if v=1 and a=0 at a clk edge, latch d into the holding register, set a<=1, go to HEAD.
//     Otherwise a<=0.
//   - Registered a is high for exactly one cycle. The capture guard a=0 prevents a double-take of
//     the same word. The producer drops v, or presents a new d, on the edge where it sees a=1.
//   - HEAD: flit = {1'b0, zero-pad, code}. When !isfull, go to BODY with cnt=0.
//   - BODY: flit = {tail, payload[cnt*DataWidth +: DataWidth]}. Bits above NPCdata are zero-padded.
//     tail = (cnt==NCHUNK-1). When !isfull: if tail, go to IDLE; else cnt<=cnt+1.
// - FIFO write (combinational):
//   - wrreq = (state!=IDLE) & !isfull
//   - data_out = flit mux of the current state/cnt; it is 0 in IDLE
// - Full: while isfull=1, wrreq=0 and state, cnt and the flit are held. Resume on the first cycle
//   isfull=0. No flit is lost or duplicated.
// - Latency: word captured at edge N; flits written at edges N+1..N+1+NCHUNK when the FIFO is never
//   full. Back in IDLE after the last write; earliest next capture is the edge after that.
// - A new word with v=1 while busy is not acked; it waits until IDLE. The holding register is never
//   overwritten mid-packet.
// - Flits are emitted LSB chunk first; the code always precedes the payload.
// - Ordering: packets leave in Channel acceptance order.
// TESTING
// - Reset pulse then idle (v=0, isfull=0) -> a=0, wrreq=0 and data_out=0 for all cycles.
// - d=32'hA5123456, v held until a, isfull=0 -> one a pulse at the capture edge. Then four
//   consecutive wrreq cycles with data_out = 11'h0A5, 11'h056, 11'h08D, 11'h401.
// - Same word with isfull=1 for 3 cycles during the 2nd flit -> wrreq=0 and data_out=11'h056 held
//   during the stall, then the remaining flits are written in order. 4 writes total, no duplicates.
// - Back-to-back words 32'h01000001 and 32'hFFFFFFFF, v never dropped:
//   - flits 11'h001, 11'h001, 11'h000, 11'h400, then 11'h0FF, 11'h3FF, 11'h3FF, 11'h40F
//   - exactly two a pulses, the 2nd only after 11'h400 is written
// - Async reset asserted mid-packet, after the 2nd flit -> wrreq and a drop immediately. After
//   release with v=0, no further flits. The next word is serialized from its head flit.
// - v held high across the a pulse for the same word (slow producer) -> the word is captured once,
//   and only 4 flits are written.

Source files
------------

// File: rtl/bz_serializer.sv
// bz_serializer
// PC->BrainDrop direction of the router. Takes one {code, payload} word from
// the PC-side channel and emits it as a wormhole packet into the BrainDrop-side
// input FIFO: one head flit carrying the code, then NCHUNK payload flits
// (LSB chunk first). Only the last flit carries tail=1.
//
// Ports
//   clk               clock, posedge
//   reset             asynchronous, active-high; drops any partial packet
//   PC_in_channel_d   input word {code, payload}
//   PC_in_channel_v   input word valid
//   PC_in_channel_a   registered ack, one-cycle pulse per word consumed
//   isfull            BrainDrop-side FIFO full
//   data_out          flit {tail, data[DataWidth-1:0]}
//   wrreq             FIFO write strobe; flit is written on the clk edge when high
module bz_serializer #(
    parameter int NPCcode   = 8,
    parameter int NPCdata   = 24,
    parameter int DataWidth = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NPCcode+NPCdata-1:0] PC_in_channel_d,
    input  logic                       PC_in_channel_v,
    output logic                       PC_in_channel_a,
    input  logic                       isfull,
    output logic [DataWidth:0]         data_out,
    output logic                       wrreq
);

    localparam int W      = NPCcode + NPCdata;
    localparam int NCHUNK = (NPCdata + DataWidth - 1) / DataWidth;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PADW   = NCHUNK * DataWidth;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [W-1:0]    hold;
    logic            capture;
    logic            a_next;
    logic            tail;
    logic [PADW-1:0] payload_pad;

    // Payload zero-extended to a whole number of chunks so the last chunk
    // picks up zero padding above NPCdata.
    assign payload_pad = PADW'(hold[NPCdata-1:0]);
    assign tail        = (cnt == LAST);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        a_next     = 1'b0;
        capture    = 1'b0;
        wrreq      = 1'b0;
        data_out   = '0;
        case (state)
            IDLE: begin
                // The a==0 guard keeps a word still presented on the ack
                // cycle from being taken twice.
                if (PC_in_channel_v && !PC_in_channel_a) begin
                    capture    = 1'b1;
                    a_next     = 1'b1;
                    state_next = HEAD;
                end
            end
            HEAD: begin
                wrreq    = !isfull;
                data_out = {1'b0, DataWidth'(hold[W-1 -: NPCcode])};
                if (!isfull) begin
                    state_next = BODY;
                    cnt_next   = '0;
                end
            end
            BODY: begin
                wrreq    = !isfull;
                data_out = {tail, payload_pad[int'(cnt)*DataWidth +: DataWidth]};
                if (!isfull) begin
                    if (tail) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            PC_in_channel_a <= 1'b0;
            hold            <= '0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            PC_in_channel_a <= a_next;
            if (capture) begin
                hold <= PC_in_channel_d;
            end
        end
    end

endmodule

// File: tb/tb_bz_serializer.sv
// tb_bz_serializer
// Directed bench for bz_serializer with default parameters (8/24/10).
// A negedge monitor records every flit presented with wrreq=1 (it is written
// on the following posedge) and counts ack pulses. Inputs change 1 time unit
// after posedge.
module tb_bz_serializer;

    logic        clk;
    logic        reset;
    logic [31:0] d;
    logic        v;
    logic        a;
    logic        isfull;
    logic [10:0] data_out;
    logic        wrreq;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [10:0] flits[$];
    int unsigned a_count;
    int unsigned flits_at_ack2;
    logic [10:0] last_at_ack2;
    bit          timed_out;

    bz_serializer #(
        .NPCcode  (8),
        .NPCdata  (24),
        .DataWidth(10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .PC_in_channel_d(d),
        .PC_in_channel_v(v),
        .PC_in_channel_a(a),
        .isfull         (isfull),
        .data_out       (data_out),
        .wrreq          (wrreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrreq) flits.push_back(data_out);
        if (a) a_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        flits.delete();
        a_count = 0;
    endtask

    // Present d with v=1 until the ack is seen; sets timed_out on no ack.
    task automatic wait_ack();
        timed_out = 1'b0;
        for (int unsigned i = 0; i < 50; i++) begin
            step();
            if (a) return;
        end
        timed_out = 1'b1;
    endtask

    task automatic wait_flits(input int unsigned n);
        timed_out = 1'b0;
        for (int unsigned i = 0; i < 60; i++) begin
            if (flits.size() >= n) return;
            step();
        end
        timed_out = (flits.size() < n);
    endtask

    task automatic test_reset();
        reset = 1'b1; v = 1'b0; isfull = 1'b0; d = '0;
        #3;
        checks++;
        if (a !== 1'b0 || wrreq !== 1'b0 || data_out !== 11'h000) begin
            errors++;
            $display("FAIL reset_during: a=%b wrreq=%b data_out=%h, required 0/0/000", a, wrreq, data_out);
        end
        step();
        reset = 1'b0;
        clear_log();
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (a !== 1'b0 || wrreq !== 1'b0 || data_out !== 11'h000) begin
                errors++;
                $display("FAIL reset_idle[%0d]: a=%b wrreq=%b data_out=%h, required 0/0/000", i, a, wrreq, data_out);
            end
        end
        step();
    endtask

    task automatic test_basic();
        logic [10:0] exp[4];
        exp = '{11'h0A5, 11'h056, 11'h08D, 11'h401};
        clear_log();
        d = 32'hA5123456; v = 1'b1;
        wait_ack();
        v = 1'b0;
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL basic_ack: no ack within budget, required one ack");
        end
        @(negedge clk);
        checks++;
        if (wrreq !== 1'b1 || data_out !== 11'h0A5) begin
            errors++;
            $display("FAIL basic_first_latency: wrreq=%b data_out=%h, required 1/0a5", wrreq, data_out);
        end
        wait_flits(4);
        repeat (4) step();
        checks++;
        if (flits.size() != 4 || a_count != 1) begin
            errors++;
            $display("FAIL basic_count: flits=%0d acks=%0d, required 4/1", flits.size(), a_count);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < flits.size()) begin
                checks++;
                if (flits[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL basic_flit[%0d]: got %h, required %h", i, flits[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [10:0] exp[4];
        exp = '{11'h0A5, 11'h056, 11'h08D, 11'h401};
        clear_log();
        d = 32'hA5123456; v = 1'b1;
        wait_ack();
        v = 1'b0;
        step();              // head flit written on this edge
        isfull = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wrreq !== 1'b0 || data_out !== 11'h056) begin
                errors++;
                $display("FAIL stall_hold[%0d]: wrreq=%b data_out=%h, required 0/056", i, wrreq, data_out);
            end
            step();
        end
        isfull = 1'b0;
        wait_flits(4);
        repeat (4) step();
        checks++;
        if (flits.size() != 4 || a_count != 1) begin
            errors++;
            $display("FAIL stall_count: flits=%0d acks=%0d, required 4/1", flits.size(), a_count);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < flits.size()) begin
                checks++;
                if (flits[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL stall_flit[%0d]: got %h, required %h", i, flits[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp[8];
        exp = '{11'h001, 11'h001, 11'h000, 11'h400, 11'h0FF, 11'h3FF, 11'h3FF, 11'h40F};
        clear_log();
        d = 32'h01000001; v = 1'b1;
        wait_ack();
        d = 32'hFFFFFFFF;    // v stays high
        wait_ack();
        flits_at_ack2 = flits.size();
        last_at_ack2  = (flits.size() > 0) ? flits[$] : 11'h7FF;
        v = 1'b0;
        checks++;
        if (flits_at_ack2 != 4 || last_at_ack2 !== 11'h400) begin
            errors++;
            $display("FAIL b2b_ack2_timing: flits_before=%0d last=%h, required 4/400", flits_at_ack2, last_at_ack2);
        end
        wait_flits(8);
        repeat (4) step();
        checks++;
        if (flits.size() != 8 || a_count != 2) begin
            errors++;
            $display("FAIL b2b_count: flits=%0d acks=%0d, required 8/2", flits.size(), a_count);
        end
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < flits.size()) begin
                checks++;
                if (flits[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_flit[%0d]: got %h, required %h", i, flits[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] exp[4];
        exp = '{11'h001, 11'h001, 11'h000, 11'h400};
        clear_log();
        d = 32'hA5123456; v = 1'b1;
        wait_ack();
        v = 1'b0;
        step();              // head written
        step();              // first payload flit written
        #2 reset = 1'b1;     // mid-cycle, away from any edge
        #1;
        checks++;
        if (wrreq !== 1'b0 || a !== 1'b0 || data_out !== 11'h000) begin
            errors++;
            $display("FAIL async_reset_drop: wrreq=%b a=%b data_out=%h, required 0/0/000", wrreq, a, data_out);
        end
        step();
        #2 reset = 1'b0;
        repeat (6) step();
        checks++;
        if (flits.size() != 2) begin
            errors++;
            $display("FAIL async_reset_partial: flits=%0d, required 2", flits.size());
        end
        clear_log();
        d = 32'h01000001; v = 1'b1;
        wait_ack();
        v = 1'b0;
        wait_flits(4);
        repeat (4) step();
        checks++;
        if (flits.size() != 4) begin
            errors++;
            $display("FAIL async_reset_next_count: flits=%0d, required 4", flits.size());
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < flits.size()) begin
                checks++;
                if (flits[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL async_reset_next_flit[%0d]: got %h, required %h", i, flits[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_slow_producer();
        clear_log();
        d = 32'hA5123456; v = 1'b1;
        wait_ack();
        repeat (2) step();   // v still high past the ack
        v = 1'b0;
        wait_flits(4);
        repeat (6) step();
        checks++;
        if (flits.size() != 4 || a_count != 1) begin
            errors++;
            $display("FAIL slow_producer: flits=%0d acks=%0d, required 4/1", flits.size(), a_count);
        end
        if (flits.size() >= 4) begin
            checks++;
            if (flits[0] !== 11'h0A5 || flits[3] !== 11'h401) begin
                errors++;
                $display("FAIL slow_producer_ends: first=%h last=%h, required 0a5/401", flits[0], flits[3]);
            end
        end
    endtask

    initial begin
        a_count = 0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_slow_producer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
